// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: stall bit positions, divider FSM states and mask helper shared by the hazard controller.
package hazard_ctrl_pkg;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;
    localparam int STALL_W   = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Stall request that freezes every stage from the PC up to and including stage top.
    function automatic logic [STALL_W-1:0] upto(input int top);
        upto = '0;
        for (int k = 0; k <= top; k++) upto[k] = 1'b1;
    endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use compare between the EX load destination and the ID source registers.
module hazard_detect (
    input  logic       id_re1,
    input  logic       id_re2,
    input  logic [4:0] id_raddr1,
    input  logic [4:0] id_raddr2,
    input  logic       ex_wreg,
    input  logic [4:0] ex_waddr,
    input  logic       ex_is_load,
    output logic       load_use
);
    assign load_use = ex_is_load && ex_wreg && ex_waddr != 5'd0 &&
                      ((id_re1 && id_raddr1 == ex_waddr) || (id_re2 && id_raddr2 == ex_waddr));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use detection, iterative divider sequencing and per-stage stall merge.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_re1,
    input  logic       id_re2,
    input  logic [4:0] id_raddr1,
    input  logic [4:0] id_raddr2,
    input  logic       ex_wreg,
    input  logic [4:0] ex_waddr,
    input  logic       ex_is_load,
    input  logic       div_req,
    input  logic       mem_wait,
    input  logic       flush,
    output logic [5:0] stall,
    output logic       div_go,
    output logic       div_done,
    output logic       load_use
);
    localparam int CNT_W = $clog2(DIV_CYCLES);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lu_raw;
    logic             div_stall;
    logic [5:0]       req;

    hazard_detect u_detect (
        .id_re1     (id_re1),
        .id_re2     (id_re2),
        .id_raddr1  (id_raddr1),
        .id_raddr2  (id_raddr2),
        .ex_wreg    (ex_wreg),
        .ex_waddr   (ex_waddr),
        .ex_is_load (ex_is_load),
        .load_use   (lu_raw)
    );

    // A flush kills the instructions behind it, so only the memory wait survives.
    assign load_use  = !flush && lu_raw;
    assign div_go    = !flush && state == IDLE && div_req;
    assign div_done  = !flush && state == DIV_DONE;
    assign div_stall = !flush && (state == DIV_BUSY || (state == IDLE && div_req));
    assign req       = ({STALL_W{mem_wait}}  & upto(STALL_MEM)) |
                       ({STALL_W{div_stall}} & upto(STALL_EX))  |
                       ({STALL_W{load_use}}  & upto(STALL_ID));

    // Any frozen stage also freezes everything upstream of it.
    always_comb begin
        stall = '0;
        for (int k = 0; k < STALL_WB; k++) stall[k] = |(req >> k);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: if (div_req) begin
                    state_nxt = DIV_BUSY;
                    cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                end
                DIV_BUSY: if (cnt == '0) state_nxt = DIV_DONE;
                          else cnt_nxt = cnt - CNT_W'(1);
                DIV_DONE: if (!stall[STALL_EX]) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for load-use, divide sequencing, mem_wait, flush and reset.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_re1, id_re2, ex_wreg, ex_is_load, div_req, mem_wait, flush;
    logic [4:0] id_raddr1, id_raddr2, ex_waddr;
    logic [5:0] stall;
    logic       div_go, div_done, load_use;
    int         n_cmp = 0;
    int         n_bad = 0;

    hazard_ctrl #(.DIV_CYCLES(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_re1     (id_re1),
        .id_re2     (id_re2),
        .id_raddr1  (id_raddr1),
        .id_raddr2  (id_raddr2),
        .ex_wreg    (ex_wreg),
        .ex_waddr   (ex_waddr),
        .ex_is_load (ex_is_load),
        .div_req    (div_req),
        .mem_wait   (mem_wait),
        .flush      (flush),
        .stall      (stall),
        .div_go     (div_go),
        .div_done   (div_done),
        .load_use   (load_use)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_re1 = 0; id_re2 = 0; id_raddr1 = 0; id_raddr2 = 0;
        ex_wreg = 0; ex_waddr = 0; ex_is_load = 0;
        div_req = 0; mem_wait = 0; flush = 0;
    endtask

    task automatic check_all(input string tag, input logic [5:0] s, input logic g, input logic d, input logic l);
        check({tag, ".stall"}, 8'(stall), 8'(s));
        check({tag, ".go"}, 8'(div_go), 8'(g));
        check({tag, ".done"}, 8'(div_done), 8'(d));
        check({tag, ".lu"}, 8'(load_use), 8'(l));
    endtask

    // Divide starting in cycle 0; expected windows are supplied by the caller.
    task automatic div_run(input string tag, input int last, input int req_last, input int mw_lo, input int mw_hi,
                           input int fl_at, input int s_hi, input int d_lo, input int d_hi);
        logic [5:0] s;
        for (int c = 0; c <= last; c++) begin
            div_req  = c <= req_last;
            mem_wait = c >= mw_lo && c <= mw_hi;
            flush    = c == fl_at;
            #1;
            s = (c >= mw_lo && c <= mw_hi) ? 6'b011111 : (c <= s_hi) ? 6'b001111 : 6'b000000;
            check_all($sformatf("%s.c%0d", tag, c), s, c == 0, c >= d_lo && c <= d_hi, 1'b0);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        tick();
        check_all("reset", 6'b0, 0, 0, 0);
        rst = 0;
        tick();
        check_all("post_reset", 6'b0, 0, 0, 0);

        ex_is_load = 1; ex_wreg = 1; ex_waddr = 5; id_re2 = 1; id_raddr2 = 5;
        #1 check_all("lu_port2", 6'b000111, 0, 0, 1);
        tick();
        idle_inputs();
        #1 check_all("lu_cleared", 6'b0, 0, 0, 0);
        ex_is_load = 1; ex_wreg = 1; ex_waddr = 0; id_re2 = 1; id_raddr2 = 0;
        #1 check_all("lu_r0", 6'b0, 0, 0, 0);
        ex_waddr = 9; id_re2 = 0; id_raddr2 = 9;
        #1 check_all("lu_noread", 6'b0, 0, 0, 0);
        id_re1 = 1; id_raddr1 = 9;
        #1 check_all("lu_port1", 6'b000111, 0, 0, 1);
        ex_wreg = 0;
        #1 check_all("lu_nowreg", 6'b0, 0, 0, 0);
        ex_wreg = 1; mem_wait = 1;
        #1 check_all("lu_memwait", 6'b011111, 0, 0, 1);
        flush = 1;
        #1 check_all("lu_flush", 6'b011111, 0, 0, 0);
        idle_inputs();
        tick();

        div_run("div", 34, 33, -1, -1, -1, 32, 33, 33);
        div_run("div_mw", 37, 36, 33, 35, -1, 32, 33, 36);
        div_run("div_busy_mw", 34, 33, 10, 12, -1, 32, 33, 33);
        div_run("div_flush", 40, 10, -1, -1, 10, 9, -1, -1);

        div_run("div_pre_rst", 4, 4, -1, -1, -1, 4, -1, -1);
        div_req = 1; rst = 1;
        #1 check_all("rst_c5", 6'b001111, 0, 0, 0);
        tick();
        div_req = 0; rst = 0;
        #1 check_all("rst_c6", 6'b0, 0, 0, 0);
        tick();
        div_run("div_after_rst", 34, 33, -1, -1, -1, 32, 33, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
